// File: rtl/fp_normalizer.sv
// fp_normalizer: post-add normalization stage. Right-shifts once on carry-out,
// otherwise left-shifts one bit per cycle until the MSB is set or the exponent runs out.
// Revision: 1.0
`default_nettype none

module fp_normalizer #(
  parameter int WIDTH = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             co_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic             sign_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             sign_o,
  output logic             sticky_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             unf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] mant, mant_nx;
  logic [EXP_W-1:0] exp_r, exp_nx;
  logic             sign, sign_nx;
  logic             sticky, sticky_nx;
  logic             zero, zero_nx;
  logic             ovf, ovf_nx;
  logic             unf, unf_nx;

  // Extra bit on the increment so an all-ones exponent is caught before wrapping.
  logic [EXP_W:0]   exp_inc;
  logic [EXP_W-1:0] exp_dec;

  assign exp_inc = {1'b0, exp_i} + {{EXP_W{1'b0}}, 1'b1};
  assign exp_dec = exp_r - {{(EXP_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mant   <= '0;
      exp_r  <= '0;
      sign   <= 1'b0;
      sticky <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      state  <= state_nx;
      mant   <= mant_nx;
      exp_r  <= exp_nx;
      sign   <= sign_nx;
      sticky <= sticky_nx;
      zero   <= zero_nx;
      ovf    <= ovf_nx;
      unf    <= unf_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mant_nx   = mant;
    exp_nx    = exp_r;
    sign_nx   = sign;
    sticky_nx = sticky;
    zero_nx   = zero;
    ovf_nx    = ovf;
    unf_nx    = unf;

    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nx   = sign_i;
          sticky_nx = 1'b0;
          zero_nx   = 1'b0;
          ovf_nx    = 1'b0;
          unf_nx    = 1'b0;
          state_nx  = DONE;
          if (co_i) begin
            if (exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
              ovf_nx  = 1'b1;
              exp_nx  = {EXP_W{1'b1}};
              mant_nx = '0;
            end else begin
              mant_nx   = {1'b1, operand[WIDTH-1:1]};
              sticky_nx = operand[0];
              exp_nx    = exp_inc[EXP_W-1:0];
            end
          end else if (operand == '0) begin
            zero_nx = 1'b1;
            exp_nx  = '0;
            mant_nx = '0;
          end else if (operand[WIDTH-1]) begin
            mant_nx = operand;
            exp_nx  = exp_i;
          end else if (exp_i == '0) begin
            unf_nx  = 1'b1;
            mant_nx = operand;
            exp_nx  = '0;
          end else begin
            mant_nx  = operand;
            exp_nx   = exp_i;
            state_nx = SHIFT;
          end
        end
      end

      SHIFT: begin
        mant_nx = {mant[WIDTH-2:0], 1'b0};
        exp_nx  = exp_dec;
        // Exponent exhaustion wins even when this shift lands the MSB.
        if (exp_dec == '0) begin
          unf_nx   = 1'b1;
          state_nx = DONE;
        end else if (mant[WIDTH-2]) begin
          state_nx = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          sticky_nx = 1'b0;
          zero_nx   = 1'b0;
          ovf_nx    = 1'b0;
          unf_nx    = 1'b0;
          state_nx  = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mant_o    = mant;
  assign exp_o     = exp_r;
  assign sign_o    = sign;
  assign sticky_o  = sticky;
  assign zero_o    = zero;
  assign ovf_o     = ovf;
  assign unf_o     = unf;

endmodule

`default_nettype wire

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed self-checking bench for fp_normalizer at WIDTH=8, EXP_W=8.
// Revision: 1.0
`default_nettype none

module tb_fp_normalizer;

  localparam int WIDTH = 8;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] operand = '0;
  logic             co_i = 1'b0;
  logic [EXP_W-1:0] exp_i = '0;
  logic             sign_i = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] mant_o;
  logic [EXP_W-1:0] exp_o;
  logic             sign_o;
  logic             sticky_o;
  logic             zero_o;
  logic             ovf_o;
  logic             unf_o;

  int checks = 0;
  int failures = 0;

  fp_normalizer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .co_i(co_i), .exp_i(exp_i), .sign_i(sign_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_o(mant_o), .exp_o(exp_o), .sign_o(sign_o),
    .sticky_o(sticky_o), .zero_o(zero_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {sticky, zero, ovf, unf}.
  task automatic run(input string tag, input logic [7:0] op, input logic co, input logic [7:0] e,
                     input logic s, input int lat_e, input logic [7:0] mant_e,
                     input logic [7:0] exp_e, input logic [3:0] flags_e);
    int lat;
    @(negedge clk);
    operand  = op;
    co_i     = co;
    exp_i    = e;
    sign_i   = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_e);
    check({tag, "_mant"}, mant_o, mant_e);
    check({tag, "_exp"}, exp_o, exp_e);
    check({tag, "_sign"}, sign_o, s);
    check({tag, "_flags"}, {sticky_o, zero_o, ovf_o, unf_o}, flags_e);
    check({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ack_valid"}, out_valid, 1'b0);
    check({tag, "_ack_ready"}, in_ready, 1'b1);
    check({tag, "_ack_flags"}, {sticky_o, zero_o, ovf_o, unf_o}, 4'b0000);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_ready", in_ready, 1'b1);
    check("reset_mant", mant_o, 8'h00);
    check("reset_flags", {sticky_o, zero_o, ovf_o, unf_o, sign_o}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run("pass", 8'h80, 1'b0, 8'd10, 1'b1, 1, 8'h80, 8'd10, 4'b0000);
    ack("pass");
    run("shift6", 8'h03, 1'b0, 8'd20, 1'b0, 7, 8'hC0, 8'd14, 4'b0000);
    ack("shift6");
    run("carry0", 8'h00, 1'b1, 8'd5, 1'b0, 1, 8'h80, 8'd6, 4'b0000);
    ack("carry0");
    run("carry_st", 8'h03, 1'b1, 8'd5, 1'b1, 1, 8'h81, 8'd6, 4'b1000);
    ack("carry_st");
    run("zero", 8'h00, 1'b0, 8'd40, 1'b0, 1, 8'h00, 8'd0, 4'b0100);
    ack("zero");
    run("unf_shift", 8'h01, 1'b0, 8'd3, 1'b0, 4, 8'h08, 8'd0, 4'b0001);
    ack("unf_shift");
    run("ovf", 8'hFF, 1'b1, 8'd254, 1'b0, 1, 8'h00, 8'hFF, 4'b0010);
    ack("ovf");
    run("unf_exp0", 8'h05, 1'b0, 8'd0, 1'b1, 1, 8'h05, 8'd0, 4'b0001);
    ack("unf_exp0");
    run("carry_hi", 8'h00, 1'b1, 8'd253, 1'b0, 1, 8'h80, 8'd254, 4'b0000);
    ack("carry_hi");

    // Stall in DONE while a competing input is offered.
    run("hold", 8'h03, 1'b0, 8'd20, 1'b1, 7, 8'hC0, 8'd14, 4'b0000);
    operand  = 8'h80;
    exp_i    = 8'd99;
    sign_i   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready", in_ready, 1'b0);
      check("hold_data", {mant_o, exp_o, sign_o}, {8'hC0, 8'd14, 1'b1});
    end
    in_valid = 1'b0;
    ack("hold");
    @(posedge clk); #1;
    check("hold_no_ghost", out_valid, 1'b0);

    // Asynchronous abort in the middle of a long shift sequence.
    @(negedge clk);
    operand  = 8'h01;
    co_i     = 1'b0;
    exp_i    = 8'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_shift", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
